// File: rtl/fetch_pc_gen_if.sv
// rtl/fetch_pc_gen_if.sv - fetch front-end bundle: pc register, imem, decode and redirect signals
interface fetch_pc_gen_if;
  logic [31:0] next_pc;
  logic [31:0] pc_value;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output next_pc,
    input  pc_value,
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_instr,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  next_pc,
    output pc_value,
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_instr,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - instruction fetch PC generator with 2-entry decode FIFO and redirect
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_pc_gen_if.master bus
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, DROP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] pc_q    [2];
  logic [31:0] pc_d    [2];
  logic [31:0] instr_q [2];
  logic [31:0] instr_d [2];

  logic        redirect;
  logic        req;
  logic        fire;
  logic        push;
  logic        valid;
  logic        pop;
  logic [1:0]  wr_slot;
  logic [31:0] next_pc;
  logic [31:0] redirect_tgt;
  logic        unused_redirect_lsbs;

  assign redirect             = bus.redirect_valid;
  assign redirect_tgt         = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  // A full FIFO is the only reason REQ withholds a request.
  assign req   = (state_q == REQ) && (count_q != 2'd2);
  assign fire  = req && bus.imem_gnt;
  assign push  = (state_q == WAIT) && bus.imem_rvalid && !redirect;
  assign valid = (count_q != 2'd0) && !redirect;
  assign pop   = valid && bus.if_ready;

  always_comb begin
    next_pc = bus.pc_value;
    if (redirect) begin
      next_pc = redirect_tgt;
    end else begin
      case (state_q)
        BOOT:    next_pc = RESET_PC;
        REQ:     next_pc = fire ? bus.pc_value + 32'd4 : bus.pc_value;
        default: next_pc = bus.pc_value;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (fire) state_d = redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) state_d = REQ;
        else if (redirect)   state_d = DROP;
      end
      DROP: begin
        if (bus.imem_rvalid) state_d = REQ;
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    req_pc_d = fire ? bus.pc_value : req_pc_q;
    count_d  = redirect ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    wr_slot  = count_q - {1'b0, pop};
    pc_d     = pc_q;
    instr_d  = instr_q;
    if (pop) begin
      pc_d[0]    = pc_q[1];
      instr_d[0] = instr_q[1];
    end
    // Writes land after the shift so a same-cycle push/pop keeps order.
    if (push) begin
      pc_d[wr_slot[0]]    = req_pc_q;
      instr_d[wr_slot[0]] = bus.imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      count_q    <= 2'd0;
      req_pc_q   <= 32'h0;
      pc_q[0]    <= 32'h0;
      pc_q[1]    <= 32'h0;
      instr_q[0] <= 32'h0;
      instr_q[1] <= 32'h0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      req_pc_q   <= req_pc_d;
      pc_q[0]    <= pc_d[0];
      pc_q[1]    <= pc_d[1];
      instr_q[0] <= instr_d[0];
      instr_q[1] <= instr_d[1];
    end
  end

  assign bus.next_pc   = next_pc;
  assign bus.imem_req  = req;
  assign bus.imem_addr = bus.pc_value;
  assign bus.if_valid  = valid;
  assign bus.if_pc     = pc_q[0];
  assign bus.if_instr  = instr_q[0];

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - scoreboard bench for fetch_pc_gen
module tb_fetch_pc_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fetch_pc_gen_if bus ();
  fetch_pc_gen_if bus2 ();

  fetch_pc_gen u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fetch_pc_gen #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 1;
  bit          mon_en = 1'b0;
  logic [31:0] exp_q [$];
  logic [31:0] q2 [$];
  logic [31:0] e;
  logic [31:0] e2;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_0013;
  endfunction

  // pc registers: load next_pc every edge, no enable
  always @(posedge clk) bus.pc_value <= bus.next_pc;
  always @(posedge clk) bus2.pc_value <= bus2.next_pc;

  // main memory: variable latency, one outstanding response
  logic        m_pend = 1'b0;
  logic [31:0] m_addr = 32'h0;
  int          m_cnt = 0;
  always @(posedge clk) begin
    logic        fire;
    logic [31:0] a;
    fire = bus.imem_req && bus.imem_gnt;
    a    = bus.imem_addr;
    #1;
    bus.imem_rvalid = 1'b0;
    if (fire) begin
      m_pend = 1'b1;
      m_addr = a;
      m_cnt  = mem_lat - 1;
    end else if (m_pend && m_cnt > 0) begin
      m_cnt = m_cnt - 1;
    end
    if (m_pend && m_cnt == 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = instr_of(m_addr);
      m_pend          = 1'b0;
    end
  end

  // second memory: fixed 1-cycle latency
  always @(posedge clk) begin
    logic        fire2;
    logic [31:0] a2;
    fire2 = bus2.imem_req && bus2.imem_gnt;
    a2    = bus2.imem_addr;
    #1;
    bus2.imem_rvalid = fire2;
    bus2.imem_rdata  = fire2 ? instr_of(a2) : 32'h0;
  end

  // scoreboard on the main decode port
  always @(negedge clk) begin
    if (mon_en && rst_n && bus.if_valid && bus.if_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got if_pc=%h if_instr=%h, required no output", bus.if_pc, bus.if_instr);
      end else begin
        e = exp_q.pop_front();
        if (bus.if_pc !== e || bus.if_instr !== instr_of(e)) begin
          errors++;
          $display("FAIL pop: got pc=%h instr=%h, required pc=%h instr=%h", bus.if_pc, bus.if_instr, e, instr_of(e));
        end
      end
    end
  end

  task automatic do_reset;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    bus.if_ready = 1'b0;
  endtask

  task automatic wait_grants(input int n, output int g);
    g = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_gnt) begin
        g++;
        if (g == n) break;
      end
    end
  endtask

  task automatic test_reset;
    mon_en = 1'b0;
    bus.if_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.next_pc !== 32'h0) begin errors++; $display("FAIL rst_next_pc: got %h, required 0", bus.next_pc); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req: got %b, required 0", bus.imem_req); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid: got %b, required 0", bus.if_valid); end
    checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc: got %h, required 0", bus.if_pc); end
    checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_instr: got %h, required 0", bus.if_instr); end
    checks++; if (bus2.next_pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL rst_next_pc2: got %h, required fffffff8", bus2.next_pc); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b, required 0", bus.imem_req); end
    checks++; if (bus.next_pc !== 32'h0) begin errors++; $display("FAIL boot_next_pc: got %h, required 0", bus.next_pc); end
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b, required 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h, required 0", bus.imem_addr); end
  endtask

  task automatic test_seq;
    bit ok;
    mon_en = 1'b1; mem_lat = 1; bus.if_ready = 1'b1;
    do_reset();
    @(negedge clk);
    checks++; if (bus.next_pc !== 32'h0) begin errors++; $display("FAIL seq_boot_next_pc: got %h, required 0", bus.next_pc); end
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    drain(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL seq_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_stall;
    bit ok;
    int g;
    mon_en = 1'b1; mem_lat = 1; bus.if_ready = 1'b0;
    do_reset();
    g = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_gnt) g++;
    end
    checks++; if (g != 2) begin errors++; $display("FAIL stall_grants: got %0d, required 2", g); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b, required 0", bus.imem_req); end
    checks++; if (bus.pc_value !== 32'h8) begin errors++; $display("FAIL stall_pc: got %h, required 8", bus.pc_value); end
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    @(posedge clk); #1;
    bus.if_ready = 1'b1;
    drain(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_redirect_wait;
    bit ok;
    bit found;
    int g;
    mon_en = 1'b1; mem_lat = 3; bus.if_ready = 1'b0;
    do_reset();
    wait_grants(2, g);
    checks++; if (g != 2) begin errors++; $display("FAIL rw_grants: got %0d, required 2", g); end
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_1003;
    @(negedge clk);
    checks++; if (bus.next_pc !== 32'h1000) begin errors++; $display("FAIL rw_next_pc: got %h, required 1000", bus.next_pc); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rw_if_valid: got %b, required 0", bus.if_valid); end
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    bus.if_ready = 1'b1;
    exp_q.push_back(32'h1000); exp_q.push_back(32'h1004);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req) begin found = 1'b1; break; end
    end
    checks++; if (!found || bus.imem_addr !== 32'h1000) begin errors++; $display("FAIL rw_addr: got req=%b addr=%h, required 1 1000", found, bus.imem_addr); end
    drain(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rw_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_redirect_gnt;
    bit ok;
    mon_en = 1'b1; mem_lat = 1; bus.if_ready = 1'b1;
    do_reset();
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rg_req: got %b, required 1", bus.imem_req); end
    checks++; if (bus.next_pc !== 32'h200) begin errors++; $display("FAIL rg_next_pc: got %h, required 200", bus.next_pc); end
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.pc_value !== 32'h200) begin errors++; $display("FAIL rg_pc: got %h, required 200", bus.pc_value); end
    drain(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rg_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_wrap;
    bit done;
    mon_en = 1'b0; bus.if_ready = 1'b0;
    do_reset();
    @(negedge clk);
    checks++; if (bus2.next_pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_boot: got %h, required fffffff8", bus2.next_pc); end
    q2.delete();
    q2.push_back(32'hFFFF_FFF8); q2.push_back(32'hFFFF_FFFC); q2.push_back(32'h0000_0000);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus2.if_valid && bus2.if_ready) begin
        e2 = q2.pop_front();
        checks++;
        if (bus2.if_pc !== e2 || bus2.if_instr !== instr_of(e2)) begin
          errors++;
          $display("FAIL wrap_pop: got pc=%h instr=%h, required pc=%h instr=%h", bus2.if_pc, bus2.if_instr, e2, instr_of(e2));
        end
        if (q2.size() == 0) done = 1'b1;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL wrap_drain: got %0d pending, required 0", q2.size()); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int g;
    mon_en = 1'b1; mem_lat = 3; bus.if_ready = 1'b0;
    do_reset();
    wait_grants(2, g);
    checks++; if (g != 2) begin errors++; $display("FAIL rm_grants: got %0d, required 2", g); end
    @(posedge clk); #1;
    checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b, required 1", bus.if_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rm_if_valid: got %b, required 0", bus.if_valid); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rm_imem_req: got %b, required 0", bus.imem_req); end
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.next_pc !== 32'h0) begin errors++; $display("FAIL rm_boot: got %h, required 0", bus.next_pc); end
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    @(posedge clk); #1;
    bus.if_ready = 1'b1;
    drain(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    bus.imem_gnt        = 1'b1;
    bus.if_ready        = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus2.imem_gnt       = 1'b1;
    bus2.if_ready       = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    test_reset();
    test_seq();
    test_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_wrap();
    test_reset_mid();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
